// File: rtl/perf_counter_unit_pkg.sv
// perf_pkg: shared widths, divider state encoding and the exported register bundle.
// Pure declarations; no timing or backpressure of its own.
package perf_pkg;

    localparam int CNT_W_DEF     = 19;
    localparam int ACC_W_DEF     = 32;
    localparam int FRAC_BITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ZERO,
        DONE
    } div_state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] stall;
        logic [CNT_W_DEF-1:0] arith;
        logic [CNT_W_DEF-1:0] mem;
        logic [CNT_W_DEF-1:0] cpi;
    } perf_regs_t;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Event strobes and host commands in, the four R28-R31 values out.
// Plain wires; no handshake, every signal is sampled every cycle.
interface perf_counter_unit_if #(
    parameter int CNT_W = perf_pkg::CNT_W_DEF
);
    logic             stall_i;
    logic             retire_i;
    logic             arith_i;
    logic             mem_i;
    logic             clear_i;
    logic             freeze_i;
    logic [CNT_W-1:0] stall_count_o;
    logic [CNT_W-1:0] aritmetric_count_o;
    logic [CNT_W-1:0] memory_count_o;
    logic [CNT_W-1:0] cpi_o;
    logic             cpi_valid_o;

    modport slave (
        input  stall_i, retire_i, arith_i, mem_i, clear_i, freeze_i,
        output stall_count_o, aritmetric_count_o, memory_count_o, cpi_o, cpi_valid_o
    );

    modport master (
        output stall_i, retire_i, arith_i, mem_i, clear_i, freeze_i,
        input  stall_count_o, aritmetric_count_o, memory_count_o, cpi_o, cpi_valid_o
    );
endinterface

// File: rtl/perf_seq_div.sv
// Restoring divider, one quotient bit per cycle: IDLE(1) + DIV(ACC_W+FRAC_BITS) + DONE(1).
// No backpressure: restarts from IDLE whenever start is high; abort returns to IDLE at once.
module perf_seq_div
    import perf_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [ACC_W+FRAC_BITS-1:0] dividend,
    input  logic [ACC_W-1:0]          divisor,
    output logic [ACC_W+FRAC_BITS-1:0] quotient,
    output logic                      done,
    output logic                      div_by_zero
);

    localparam int DVD_W  = ACC_W + FRAC_BITS;
    localparam int CNT_BW = $clog2(DVD_W);

    div_state_t         state_q, state_d;
    logic [DVD_W-1:0]   quo_q, quo_d;
    logic [ACC_W-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   dvs_q, dvs_d;
    logic [CNT_BW-1:0]  cnt_q, cnt_d;

    logic [ACC_W:0]     rem_shift;
    logic [ACC_W:0]     rem_diff;
    logic               rem_ge;

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
    assign rem_shift = {rem_q, quo_q[DVD_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign quotient  = quo_q;

    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        div_by_zero = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_BW'(DVD_W - 1);
                    state_d = (divisor == '0) ? ZERO : DIV;
                end
            end
            DIV: begin
                rem_d = rem_ge ? rem_diff[ACC_W-1:0] : rem_shift[ACC_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], rem_ge};
                cnt_d = cnt_q - CNT_BW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            ZERO: begin
                div_by_zero = 1'b1;
                state_d     = IDLE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d     = IDLE;
            done        = 1'b0;
            div_by_zero = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// R28-R31 producer: event counters + CPI; counts visible 1 cycle after the strobe, CPI every ACC_W+FRAC_BITS+2 cycles.
// No backpressure. PERF_WRAP_EN makes counters/accumulators wrap instead of saturate (CPI always saturates).
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                clkFPGA,
    input  logic                rst,
    perf_counter_unit_if.slave  bus
);

    localparam int DVD_W = ACC_W + FRAC_BITS;

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] arith_q, arith_d;
    logic [CNT_W-1:0] mem_q,   mem_d;
    logic [ACC_W-1:0] cyc_q,   cyc_d;
    logic [ACC_W-1:0] inst_q,  inst_d;
    logic [CNT_W-1:0] cpi_q,   cpi_d;
    logic             cpi_vld_q, cpi_vld_d;

    logic [DVD_W-1:0] div_quo;
    logic             div_done;
    logic             div_zero;
    logic [CNT_W-1:0] quo_sat;
    perf_regs_t       regs;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef PERF_WRAP_EN
        return v + CNT_W'(1);
`else
        return (&v) ? v : v + CNT_W'(1);
`endif
    endfunction

    function automatic logic [ACC_W-1:0] acc_inc(input logic [ACC_W-1:0] v);
`ifdef PERF_WRAP_EN
        return v + ACC_W'(1);
`else
        return (&v) ? v : v + ACC_W'(1);
`endif
    endfunction

    always_comb begin
        stall_d = stall_q;
        arith_d = arith_q;
        mem_d   = mem_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        if (!bus.freeze_i) begin
            cyc_d = acc_inc(cyc_q);
            if (bus.stall_i) begin
                stall_d = cnt_inc(stall_q);
            end
            if (bus.retire_i) begin
                inst_d = acc_inc(inst_q);
                if (bus.arith_i) begin
                    arith_d = cnt_inc(arith_q);
                end
                if (bus.mem_i) begin
                    mem_d = cnt_inc(mem_q);
                end
            end
        end
        // Host clear behaves like reset and wins over freeze and every event.
        if (bus.clear_i) begin
            stall_d = '0;
            arith_d = '0;
            mem_d   = '0;
            cyc_d   = '0;
            inst_d  = '0;
        end
    end

    perf_seq_div #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_div (
        .clk         (clkFPGA),
        .rst         (rst),
        .start       (1'b1),
        .abort       (bus.clear_i),
        .dividend    ({cyc_q, {FRAC_BITS{1'b0}}}),
        .divisor     (inst_q),
        .quotient    (div_quo),
        .done        (div_done),
        .div_by_zero (div_zero)
    );

    assign quo_sat = (|div_quo[DVD_W-1:CNT_W]) ? {CNT_W{1'b1}} : div_quo[CNT_W-1:0];

    always_comb begin
        cpi_d     = cpi_q;
        cpi_vld_d = cpi_vld_q;
        if (div_done) begin
            cpi_d     = quo_sat;
            cpi_vld_d = 1'b1;
        end else if (div_zero) begin
            cpi_d     = '0;
            cpi_vld_d = 1'b1;
        end
        if (bus.clear_i) begin
            cpi_d     = '0;
            cpi_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            stall_q   <= '0;
            arith_q   <= '0;
            mem_q     <= '0;
            cyc_q     <= '0;
            inst_q    <= '0;
            cpi_q     <= '0;
            cpi_vld_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            arith_q   <= arith_d;
            mem_q     <= mem_d;
            cyc_q     <= cyc_d;
            inst_q    <= inst_d;
            cpi_q     <= cpi_d;
            cpi_vld_q <= cpi_vld_d;
        end
    end

    always_comb begin
        regs.stall = CNT_W_DEF'(stall_q);
        regs.arith = CNT_W_DEF'(arith_q);
        regs.mem   = CNT_W_DEF'(mem_q);
        regs.cpi   = CNT_W_DEF'(cpi_q);
    end

    assign bus.stall_count_o      = regs.stall[CNT_W-1:0];
    assign bus.aritmetric_count_o = regs.arith[CNT_W-1:0];
    assign bus.memory_count_o     = regs.mem[CNT_W-1:0];
    assign bus.cpi_o              = regs.cpi[CNT_W-1:0];
    assign bus.cpi_valid_o        = cpi_vld_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: a default-width instance and a narrow one (CNT_W=8, ACC_W=12)
// share the same stimulus so that saturation is reached within a short run.
module tb_perf_counter_unit;
    import perf_pkg::*;

    localparam longint CMAX [2] = '{(longint'(1) << 19) - 1, 255};
    localparam longint AMAX [2] = '{(longint'(1) << 32) - 1, 4095};

    logic clk = 1'b0;
    logic rst;
    logic s, r, a, m, c, f;

    always #5 clk = ~clk;

    perf_counter_unit_if #(.CNT_W(CNT_W_DEF)) bus0 ();
    perf_counter_unit_if #(.CNT_W(8))         bus1 ();

    assign bus0.stall_i  = s;
    assign bus0.retire_i = r;
    assign bus0.arith_i  = a;
    assign bus0.mem_i    = m;
    assign bus0.clear_i  = c;
    assign bus0.freeze_i = f;
    assign bus1.stall_i  = s;
    assign bus1.retire_i = r;
    assign bus1.arith_i  = a;
    assign bus1.mem_i    = m;
    assign bus1.clear_i  = c;
    assign bus1.freeze_i = f;

    perf_counter_unit dut (
        .clkFPGA (clk),
        .rst     (rst),
        .bus     (bus0)
    );

    perf_counter_unit #(.CNT_W(8), .ACC_W(12), .FRAC_BITS(4)) dut_s (
        .clkFPGA (clk),
        .rst     (rst),
        .bus     (bus1)
    );

    int tests = 0;
    int fails = 0;

    longint m_stall [2];
    longint m_ar    [2];
    longint m_mem   [2];
    longint m_cyc   [2];
    longint m_inst  [2];

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint bump(input longint v, input longint mx);
`ifdef PERF_WRAP_EN
        return (v + 1) & mx;
`else
        return (v >= mx) ? mx : v + 1;
`endif
    endfunction

    function automatic longint cpi_ref(input int k);
        longint q;
        if (m_inst[k] == 0) return 0;
        q = (m_cyc[k] * 16) / m_inst[k];
        return (q > CMAX[k]) ? CMAX[k] : q;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_ar[k] = 0; m_mem[k] = 0; m_cyc[k] = 0; m_inst[k] = 0;
        end
    endtask

    task automatic check_counts();
        check("stall0", longint'(bus0.stall_count_o),      m_stall[0]);
        check("arith0", longint'(bus0.aritmetric_count_o), m_ar[0]);
        check("mem0",   longint'(bus0.memory_count_o),     m_mem[0]);
        check("stall1", longint'(bus1.stall_count_o),      m_stall[1]);
        check("arith1", longint'(bus1.aritmetric_count_o), m_ar[1]);
        check("mem1",   longint'(bus1.memory_count_o),     m_mem[1]);
    endtask

    task automatic check_cpi(input string tag, input longint vld_exp, input bit use_model);
        check({tag, "_vld0"}, longint'(bus0.cpi_valid_o), vld_exp);
        check({tag, "_vld1"}, longint'(bus1.cpi_valid_o), vld_exp);
        check({tag, "_cpi0"}, longint'(bus0.cpi_o), use_model ? cpi_ref(0) : 0);
        check({tag, "_cpi1"}, longint'(bus1.cpi_o), use_model ? cpi_ref(1) : 0);
    endtask

    // One clock: apply inputs, advance the model on the edge, compare just after it.
    task automatic step(input bit ts, input bit tr, input bit ta, input bit tm,
                        input bit tc, input bit tf);
        s = ts; r = tr; a = ta; m = tm; c = tc; f = tf;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (tc) begin
                m_stall[k] = 0; m_ar[k] = 0; m_mem[k] = 0; m_cyc[k] = 0; m_inst[k] = 0;
            end else if (!tf) begin
                m_cyc[k] = bump(m_cyc[k], AMAX[k]);
                if (ts) m_stall[k] = bump(m_stall[k], CMAX[k]);
                if (tr) begin
                    m_inst[k] = bump(m_inst[k], AMAX[k]);
                    if (ta) m_ar[k]  = bump(m_ar[k],  CMAX[k]);
                    if (tm) m_mem[k] = bump(m_mem[k], CMAX[k]);
                end
            end
        end
        #1;
        check_counts();
        if (tc) check_cpi("clr", 0, 1'b0);
    endtask

    task automatic settle_frozen(input string tag);
        repeat (90) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        check_cpi(tag, 1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        s = 0; r = 0; a = 0; m = 0; c = 0; f = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_counts();
        check_cpi("rst", 0, 1'b0);
        rst = 1'b0;

        // Nothing retires: each pass takes the zero-divisor path.
        repeat (40) step(0, 0, 0, 0, 0, 0);
        check_cpi("zero_path", 1, 1'b0);

        // Retire every other cycle, then freeze: CPI 2.0.
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) step(0, (i % 2) == 0, 0, 0, 0, 0);
        settle_frozen("cpi2");

        // Directed event counts.
        step(0, 0, 0, 0, 1, 0);
        repeat (5) step(0, 1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 1, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);

        // Stall held long enough to hit the narrow instance's ceiling.
        step(0, 0, 0, 0, 1, 0);
        repeat (266) step(1, 0, 0, 0, 0, 0);

        // Clear mid-divide with a stall in the same cycle, then watch the restart.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check_cpi("restart_a", 0, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        check_cpi("restart_b", 1, 1'b0);
        repeat (10) step(0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check_cpi("abort_a", 0, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        check_cpi("abort_b", 1, 1'b0);

        // Random traffic with occasional clears and freezes.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
        end
        settle_frozen("cpi_rand");

        // One retirement in a long quiet window: CPI saturates.
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (33000) step(0, 0, 0, 0, 0, 0);
        settle_frozen("cpi_sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
Producer side of the CPU performance-monitor registers R28–R31.
- Counts stall cycles, arithmetic instructions and memory instructions from datapath event strobes.
- Computes cycles-per-instruction (CPI) in fixed point using a sequential divider.
- Drives the four 19-bit values that the in-system probe blocks read.
- Accepts clear/freeze commands from the in-system source outputs, so the host can control the counters it reads.

Parameters:
- CNT_W, 19, width of every exported value
- ACC_W, 32, width of the internal cycle and retired-instruction accumulators
- FRAC_BITS, 4, fractional bits of the CPI result (unsigned Q(CNT_W-FRAC_BITS).FRAC_BITS)

Ports:
- clkFPGA  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  pipeline stalled this cycle
- retire_i  in  1  one instruction retired this cycle
- arith_i  in  1  retired instruction is arithmetic (qualified by retire_i)
- mem_i  in  1  retired instruction is load/store (qualified by retire_i)
- clear_i  in  1  host clear command (level; acts every cycle it is high)
- freeze_i  in  1  host freeze: counters hold while high
- stall_count_o  out  CNT_W  R28 value
- aritmetric_count_o  out  CNT_W  R29 value
- memory_count_o  out  CNT_W  R30 value
- cpi_o  out  CNT_W  R31 value, CPI × 2^FRAC_BITS
- cpi_valid_o  out  1  cpi_o holds a completed result

Behaviour:
- Reset: all outputs 0; accumulators 0; divider FSM in IDLE. Clear (clear_i=1) has exactly the same effect as rst and dominates every event in the same cycle.
- Counting: registered; an event in cycle n is visible on the output in cycle n+1.
  - stall_count increments on stall_i.
  - cycle_acc increments every cycle.
  - instret_acc increments on retire_i.
  - aritmetric_count increments on retire_i & arith_i; memory_count on retire_i & mem_i.
  - arith_i/mem_i are ignored when retire_i=0.
- Saturation: CNT_W outputs stop at 2^CNT_W−1; accumulators stop at 2^ACC_W−1. There is no wrap-around.
- freeze_i=1: all counters and accumulators hold; the divider keeps running; clear_i still acts.
- Divider FSM (sub-module):
  - IDLE: capture snapshots of cycle_acc and instret_acc. If the instret snapshot is 0, go to ZERO; otherwise go to DIV.
  - DIV: restoring divide of (cycle_snap << FRAC_BITS) by instret_snap, one quotient bit per cycle, ACC_W+FRAC_BITS cycles, then go to DONE.
  - ZERO: cpi_o←0, cpi_valid_o←1, go to IDLE.
  - DONE: cpi_o←quotient saturated to CNT_W bits; cpi_valid_o←1; go to IDLE.
  - Update period is therefore ACC_W+FRAC_BITS+2 cycles (38 with defaults). cpi_o holds its value between updates.
- Clear or rst during DIV: divider aborts to IDLE, partial quotient discarded, cpi_valid_o←0.
- Snapshots are taken only in IDLE; counting during DIV is not reflected until the next pass.

Optional Feature:
- Macro: PERF_WRAP_EN.
- Defined: exported counters and accumulators wrap modulo 2^width instead of saturating; cpi_o is still saturated.
- Undefined (default): saturating behaviour as specified above.

Decomposition:
- Package perf_pkg contains:
  - CNT_W/ACC_W/FRAC_BITS default constants
  - div_state_t enum {IDLE, DIV, ZERO, DONE}
  - struct perf_regs_t bundling the four exported values
- Sub-module perf_seq_div contains:
  - the divider FSM
  - inputs: start, dividend (ACC_W+FRAC_BITS), divisor (ACC_W), abort
  - outputs: quotient, done, div_by_zero
- The top level holds the counters and result registers.

Test Plan:
- Reset, then hold retire_i=0 → all outputs 0. After the first pass (≤38 cycles) cpi_valid_o=1 with cpi_o=0 (ZERO path).
- Clear, then retire_i on alternate cycles for 100 cycles, then freeze_i=1 → next completed result cpi_o=32 (2.0×16). Counters hold while frozen.
- 5 cycles with retire_i & arith_i, 3 cycles with retire_i & mem_i, 4 cycles with stall_i → aritmetric_count_o=5, memory_count_o=3, stall_count_o=4, each updating one cycle after its strobe.
- Force stall_i high for 2^19+10 cycles → stall_count_o=524287 and stays there. With PERF_WRAP_EN defined → 10.
- Assert clear_i for one cycle mid-DIV together with stall_i=1 → next cycle all outputs 0, cpi_valid_o=0, stall not counted, divider restarts from IDLE.
- retire_i once in 1,000,000 cycles (CPI ≈ 10^6) → cpi_o saturates at 524287.
